// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline stages.
package mips_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // RUN means an instruction response is outstanding on the memory read port
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory, presents {instr, pc, pc+4} to decode.
// Latency: 1 cycle from address issue (or redirect) to if_valid.
// Backpressure: stall holds the response by re-reading the same address; no skid buffer.
module inst_fetch_unit #(
  parameter int                      ADDR_W   = mips_pkg::ADDR_W,
  parameter int                      INSTR_W  = mips_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_en,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  output logic                       if_valid,
  output logic [INSTR_W-1:0]         if_instr,
  output logic [ADDR_W-1:0]          if_pc,
  output logic [ADDR_W-1:0]          if_pc_plus4,
  output logic                       align_err,
  output logic [31:0]                fetch_count
);

  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] rsp_pc_q;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              rsp_valid_q;
  logic              hold;
  logic              transfer;

  assign rsp_valid_q  = (state_q == RUN);
  assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign hold         = rsp_valid_q & stall & ~redirect_valid;
  assign transfer     = rsp_valid_q & ~stall;

  always_comb begin
    imem_addr = pc_q;
    if (redirect_valid)
      imem_addr = redirect_tgt;
    else if (hold)
      imem_addr = rsp_pc_q;
  end

  // Redirect wins over stall; a held or in-flight instruction is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      if (fetch_en) begin
        state_q  <= RUN;
        rsp_pc_q <= redirect_tgt;
        pc_q     <= redirect_tgt + PC_STEP;
      end else begin
        state_q  <= IDLE;
        pc_q     <= redirect_tgt;
      end
    end else if (hold) begin
      state_q  <= state_q;
    end else if (fetch_en) begin
      state_q  <= RUN;
      rsp_pc_q <= pc_q;
      pc_q     <= pc_q + PC_STEP;
    end else begin
      state_q  <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err   <= 1'b0;
      fetch_count <= '0;
    end else begin
      align_err <= redirect_valid & (|redirect_pc[1:0]);
      if (transfer)
        fetch_count <= fetch_count + 32'd1;
    end
  end

  assign if_valid    = rsp_valid_q;
  assign if_instr    = imem_rdata;
  assign if_pc       = rsp_pc_q;
  assign if_pc_plus4 = rsp_pc_q + PC_STEP;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit paired with a registered instruction memory holding mem[a] = a.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        align_err;
  logic [31:0] fetch_count;

  int n_checks;
  int n_fails;

  inst_fetch_unit #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4),
    .align_err     (align_err),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word at address a contains a, data registered on the clock edge
  always @(posedge clk) imem_rdata <= imem_addr;

  typedef struct {
    logic        fe;
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_align;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fe, input logic st, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc, input logic eal, input logic [31:0] ecnt);
    vec_t v;
    v.fe = fe; v.st = st; v.rv = rv; v.rpc = rpc;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_align = eal; v.exp_count = ecnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fe, input logic st, input logic rv, input logic [31:0] rpc);
    fetch_en = fe; stall = st; redirect_valid = rv; redirect_pc = rpc;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input int idx, input vec_t v);
    logic [31:0] exp_plus4;
    exp_plus4 = v.exp_pc + 32'd4;
    check($sformatf("v%0d if_valid", idx), {31'd0, if_valid}, {31'd0, v.exp_valid});
    if (v.exp_valid) begin
      check($sformatf("v%0d if_pc", idx), if_pc, v.exp_pc);
      check($sformatf("v%0d if_instr", idx), if_instr, v.exp_pc);
      check($sformatf("v%0d if_pc_plus4", idx), if_pc_plus4, exp_plus4);
    end
    check($sformatf("v%0d align_err", idx), {31'd0, align_err}, {31'd0, v.exp_align});
    check($sformatf("v%0d fetch_count", idx), fetch_count, v.exp_count);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    //  fe st rv  redirect_pc     valid  pc            align count
    add(1, 0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'd0);   // first fetch after reset
    add(1, 0, 0, 32'h0,          1, 32'h0000_0004, 0, 32'd1);
    add(1, 0, 0, 32'h0,          1, 32'h0000_0008, 0, 32'd2);
    add(1, 1, 0, 32'h0,          1, 32'h0000_0008, 0, 32'd2);   // stall x3 holds pc 8
    add(1, 1, 0, 32'h0,          1, 32'h0000_0008, 0, 32'd2);
    add(1, 1, 0, 32'h0,          1, 32'h0000_0008, 0, 32'd2);
    add(1, 0, 0, 32'h0,          1, 32'h0000_000C, 0, 32'd3);   // 8 counted once
    add(1, 1, 1, 32'h0000_0100,  1, 32'h0000_0100, 0, 32'd3);   // redirect beats stall
    add(1, 0, 0, 32'h0,          1, 32'h0000_0104, 0, 32'd4);
    add(1, 0, 1, 32'h0000_0103,  1, 32'h0000_0100, 1, 32'd5);   // misaligned redirect
    add(1, 0, 0, 32'h0,          1, 32'h0000_0104, 0, 32'd6);
    add(1, 0, 1, 32'h0000_001C,  1, 32'h0000_001C, 0, 32'd7);   // leaves pc_q = 0x20
    add(0, 0, 0, 32'h0,          0, 32'h0,         0, 32'd8);   // bubbles, pc frozen
    add(0, 0, 0, 32'h0,          0, 32'h0,         0, 32'd8);
    add(1, 0, 0, 32'h0,          1, 32'h0000_0020, 0, 32'd8);
    add(1, 0, 1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC, 0, 32'd9);   // top of address space
    add(1, 0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'd10);  // wraps to 0
    add(0, 0, 1, 32'h0000_0040,  0, 32'h0,         0, 32'd11);  // redirect while disabled
    add(1, 1, 0, 32'h0,          1, 32'h0000_0040, 0, 32'd11);  // stall ignored when invalid
    add(1, 0, 0, 32'h0,          1, 32'h0000_0044, 0, 32'd12);

    // Reset state
    #7;
    check("rst if_valid", {31'd0, if_valid}, 32'd0);
    check("rst if_pc", if_pc, 32'h0);
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst fetch_count", fetch_count, 32'd0);
    check("rst align_err", {31'd0, align_err}, 32'd0);

    step();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].fe, vecs[i].st, vecs[i].rv, vecs[i].rpc);
      step();
      check_outputs(i, vecs[i]);
    end

    // Address mux: redirect aligns the target combinationally, hold re-reads rsp_pc
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0203);
    #1;
    check("mux redirect imem_addr", imem_addr, 32'h0000_0200);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    check("mux hold imem_addr", imem_addr, 32'h0000_0044);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    check("mux run imem_addr", imem_addr, 32'h0000_0048);
    step();
    check("pre-reset if_pc", if_pc, 32'h0000_0048);

    // Asynchronous reset mid-run drops if_valid without waiting for an edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst if_valid", {31'd0, if_valid}, 32'd0);
    check("async rst fetch_count", fetch_count, 32'd0);
    check("async rst imem_addr", imem_addr, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("restart if_valid", {31'd0, if_valid}, 32'd1);
    check("restart if_pc", if_pc, 32'h0);
    check("restart if_instr", if_instr, 32'h0);
    step();
    check("restart next if_pc", if_pc, 32'h0000_0004);
    check("restart fetch_count", fetch_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
